// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit id encodings, port indices, arbiter states,
// and small helpers for decoding the flit id field.
package noc_pkg;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_idx_e;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // A single-flit packet carries HEADER|TAIL, so test the bits individually.
  function automatic logic is_header(input logic [2:0] id);
    return (id & HEADER) != 3'b000;
  endfunction

  function automatic logic is_tail(input logic [2:0] id);
    return (id & TAIL) != 3'b000;
  endfunction

endpackage

// File: rtl/out_port_arbiter_if.sv
// Bundle between the input channels and one output port arbiter.
// master: router side (FIFOs, LBDR, downstream credits); slave: the arbiter.
interface out_port_arbiter_if #(
  parameter int NUM_REQ  = 5,
  parameter int CREDIT_W = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   empty;
  logic [3*NUM_REQ-1:0] flit_id;
  logic                 credit_in;
  logic [NUM_REQ-1:0]   grant;
  logic                 valid_out;
  logic [CREDIT_W-1:0]  credit_cnt;
  logic                 busy;

  modport master (
    output req, empty, flit_id, credit_in,
    input  grant, valid_out, credit_cnt, busy
  );

  modport slave (
    input  req, empty, flit_id, credit_in,
    output grant, valid_out, credit_cnt, busy
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: returns the first eligible index
// after ptr in circular order as a one-hot vector. Tie ptr to NUM_REQ-1 for
// plain lowest-index-wins priority.
module rr_picker #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  // Smallest circular distance from ptr+1 wins.
  always_comb begin
    int best_d;
    int best_i;
    int d;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    best_d = NUM_REQ;
    best_i = 0;
    d      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i]) begin
        d = (i - int'(ptr) - 1 + 2 * NUM_REQ) % NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          best_i = i;
        end
      end
    end
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      winner[i] = eligible[i] && (i == best_i);
    end
  end

  assign valid = |eligible;

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port packet arbiter with wormhole lock and downstream credits.
// Build option ARB_ROUND_ROBIN_EN: rotating priority, pointer advances on
// each TAIL. Without it: fixed priority N>E>W>S>L and no pointer register.
module out_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ    = 5,
  parameter int CREDIT_MAX = 4,
  parameter int CREDIT_W   = 3
) (
  input logic              clk,
  input logic              rst,
  out_port_arbiter_if.slave bus
);

  localparam int                  IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);
  localparam logic [0:0]          IDLE        = ARB_IDLE;
  localparam logic [0:0]          LOCKED      = ARB_LOCKED;

  logic [0:0]          state;
  logic [IDX_W-1:0]    owner;
  logic [CREDIT_W-1:0] credit_q;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  winner;
  logic                any_eligible;
  logic [IDX_W-1:0]    winner_idx;
  logic [IDX_W-1:0]    pick_ptr;
  logic [2:0]          owner_fid;
  logic                owner_empty;
  logic [NUM_REQ-1:0]  grant_w;
  logic                locked;
  logic                xfer;
  logic                pkt_end;

  assign locked  = (state == LOCKED);
  assign xfer    = |grant_w;
  assign pkt_end = xfer && is_tail(owner_fid);

  // An input competes only with a HEADER at the head of a non-empty FIFO.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req[i] && !bus.empty[i] && is_header(bus.flit_id[3*i +: 3]);
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  // Last-served pointer moves to the owner when its packet ends.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst)          ptr <= LAST_IDX;
    else if (pkt_end) ptr <= owner;
  end

  assign pick_ptr = ptr;
`else
  assign pick_ptr = LAST_IDX;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (pick_ptr),
    .winner   (winner),
    .valid    (any_eligible)
  );

  // Encode the winner and select the owner's head-of-FIFO status.
  always_comb begin
    winner_idx  = '0;
    owner_fid   = '0;
    owner_empty = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) winner_idx = IDX_W'(i);
      if (owner == IDX_W'(i)) begin
        owner_fid   = bus.flit_id[3*i +: 3];
        owner_empty = bus.empty[i];
      end
    end
  end

  // Read enable to the owner whenever it has a flit and downstream has room.
  always_comb begin
    grant_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_w[i] = locked && (owner == IDX_W'(i)) && !owner_empty && (credit_q != '0);
    end
  end

  // Lock on a winning HEADER, release after the TAIL transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            state <= LOCKED;
            owner <= winner_idx;
          end
        end
        LOCKED:  if (pkt_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Free downstream slots: spend on transfer, refund on credit_in, saturate.
  always_ff @(posedge clk) begin
    if (rst)                                                 credit_q <= CREDIT_FULL;
    else if (xfer && !bus.credit_in)                         credit_q <= credit_q - CREDIT_W'(1);
    else if (!xfer && bus.credit_in && credit_q != CREDIT_FULL) credit_q <= credit_q + CREDIT_W'(1);
  end

  assign bus.grant      = grant_w;
  assign bus.valid_out  = xfer;
  assign bus.credit_cnt = credit_q;
  assign bus.busy       = locked;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter: input FIFOs are modelled as
// flit queues, and a packet-level reference model predicts every cycle.
module tb_out_port_arbiter;
  import noc_pkg::*;

  localparam int NR   = 5;
  localparam int CMAX = 4;
  localparam int CW   = 3;
  localparam int QD   = 64;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_port_arbiter_if #(.NUM_REQ(NR), .CREDIT_W(CW)) bus ();

  out_port_arbiter #(.NUM_REQ(NR), .CREDIT_MAX(CMAX), .CREDIT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Input FIFO contents (flit ids), one ring per input
  logic [2:0] fmem [NR][QD];
  int         f_rd [NR];
  int         f_wr [NR];
  logic [NR-1:0] req_v;
  bit         credit_auto;
  bit         cin_pulse;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_last;
  int m_credit;

  function automatic int fsize(input int i);
    return f_wr[i] - f_rd[i];
  endfunction

  function automatic logic [2:0] head(input int i);
    return fmem[i][f_rd[i] % QD];
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push(input int i, input logic [2:0] id);
    fmem[i][f_wr[i] % QD] = id;
    f_wr[i]++;
  endtask

  task automatic push_pkt(input int i, input int len);
    if (len == 1) push(i, HEADER | TAIL);
    else begin
      push(i, HEADER);
      for (int k = 0; k < len - 2; k++) push(i, PAYLOAD);
      push(i, TAIL);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) begin
      f_rd[i] = 0;
      f_wr[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = NR - 1;
    m_credit = CMAX;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      bus.empty[i]       = (fsize(i) == 0);
      bus.flit_id[3*i +: 3] = (fsize(i) > 0) ? head(i) : 3'($urandom_range(0, 7));
    end
    bus.req       = req_v;
    bus.credit_in = credit_auto | cin_pulse;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush();
    model_reset();
    req_v       = '0;
    credit_auto = 1'b0;
    cin_pulse   = 1'b0;
    drive_inputs();
  endtask

  // One clock: drive, observe at negedge, predict, advance the FIFOs.
  // Packed layout: {grant[4:0], valid_out, busy, credit_cnt[2:0]}
  task automatic tick(output logic [9:0] obs, output logic [9:0] exp);
    int mg;
    int best;
    int idx;
    logic [NR-1:0] eg;
    bit cin;
    bit was_locked;
    drive_inputs();
    @(negedge clk);
    obs = {bus.grant, bus.valid_out, bus.busy, bus.credit_cnt};
    mg = -1;
    eg = '0;
    if (m_locked && fsize(m_owner) > 0 && m_credit > 0) begin
      mg     = m_owner;
      eg[mg] = 1'b1;
    end
    exp = {eg, (mg >= 0), m_locked, CW'(m_credit)};
    cin        = bus.credit_in;
    was_locked = m_locked;
    if (mg >= 0 && (head(mg) & TAIL) != 3'b000) begin
      m_locked = 1'b0;
      m_last   = mg;
    end
    if (!was_locked) begin
      best = -1;
      for (int k = 1; k <= NR; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
        idx = (m_last + k) % NR;
`else
        idx = k - 1;
`endif
        if (best < 0 && req_v[idx] && fsize(idx) > 0 && (head(idx) & HEADER) != 3'b000)
          best = idx;
      end
      if (best >= 0) begin
        m_locked = 1'b1;
        m_owner  = best;
      end
    end
    m_credit = m_credit + (cin ? 1 : 0) - ((mg >= 0) ? 1 : 0);
    if (m_credit > CMAX) m_credit = CMAX;
    @(posedge clk);
    #1;
    if (mg >= 0) f_rd[mg]++;
    cin_pulse = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs, exp;
    apply_reset();
    n_checks++; if (bus.grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant got=%b want=00000", bus.grant); end
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.valid_out); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.credit_cnt !== 3'd4) begin n_fail++; $display("FAIL reset_credit got=%0d want=4", bus.credit_cnt); end
    // PAYLOAD-only heads must never start a packet, whatever req says
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NR; i++) if (fsize(i) < 4 && $urandom_range(0, 1) == 1) push(i, PAYLOAD);
      req_v = 5'($urandom_range(0, 31));
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL idle_model t=%0d got=%b want=%b", t, obs, exp); end
      n_checks++; if (obs[9:3] !== 7'b0) begin n_fail++; $display("FAIL idle_no_grant t=%0d got=%b want=0000000", t, obs[9:3]); end
    end
  endtask

  task automatic test_single_packet();
    logic [9:0] obs, exp;
    logic [4:0] want_g [6];
    want_g = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    apply_reset();
    push_pkt(1, 3);
    req_v = 5'b00010;
    for (int t = 0; t < 6; t++) begin
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL single_model t=%0d got=%b want=%b", t, obs, exp); end
      n_checks++; if (obs[9:5] !== want_g[t]) begin n_fail++; $display("FAIL single_grant t=%0d got=%b want=%b", t, obs[9:5], want_g[t]); end
      if (t == 4) begin
        n_checks++; if (obs[2:0] !== 3'd1) begin n_fail++; $display("FAIL single_credit got=%0d want=1", obs[2:0]); end
        n_checks++; if (obs[3] !== 1'b0) begin n_fail++; $display("FAIL single_busy got=%b want=0", obs[3]); end
      end
    end
  endtask

  task automatic test_contention();
    logic [9:0] obs, exp;
    int order [4];
    int want [4];
    int n_ord;
    bit prev_busy;
    bit l2_pushed;
    bit done;
`ifdef ARB_ROUND_ROBIN_EN
    want = '{0, 4, 0, 4};
`else
    want = '{0, 0, 4, 4};
`endif
    order = '{-1, -1, -1, -1};
    apply_reset();
    credit_auto = 1'b1;
    push_pkt(0, 3);
    push_pkt(0, 3);
    push_pkt(4, 3);
    req_v = 5'b10001;
    n_ord = 0; prev_busy = 1'b0; l2_pushed = 1'b0; done = 1'b0;
    for (int t = 0; t < 80; t++) begin
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL contention_model t=%0d got=%b want=%b", t, obs, exp); end
      if (obs[3] && !prev_busy) begin
        if (n_ord < 4) order[n_ord] = oh_idx(obs[9:5]);
        n_ord++;
      end
      prev_busy = obs[3];
      // Re-offer L as soon as its first packet has left
      if (!l2_pushed && f_rd[4] == 3) begin
        push_pkt(4, 3);
        l2_pushed = 1'b1;
      end
      if (l2_pushed && fsize(0) == 0 && fsize(4) == 0 && !m_locked) begin
        done = 1'b1;
        break;
      end
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL contention_timeout got=busy want=drained"); end
    n_checks++; if (n_ord != 4) begin n_fail++; $display("FAIL contention_count got=%0d want=4", n_ord); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (order[i] != want[i]) begin n_fail++; $display("FAIL contention_order[%0d] got=%0d want=%0d", i, order[i], want[i]); end
    end
  endtask

  task automatic test_credit_starve();
    logic [9:0] obs, exp;
    int g_cnt;
    apply_reset();
    push_pkt(3, 6);
    req_v = 5'b01000;
    g_cnt = 0;
    for (int t = 0; t < 14; t++) begin
      if (t == 8 || t == 11) cin_pulse = 1'b1;
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL starve_model t=%0d got=%b want=%b", t, obs, exp); end
      if (t <= 7 && obs[9:5] != 5'b0) g_cnt++;
      if (t == 7) begin
        n_checks++; if (obs[2:0] !== 3'd0) begin n_fail++; $display("FAIL starve_credit got=%0d want=0", obs[2:0]); end
        n_checks++; if (g_cnt != 4) begin n_fail++; $display("FAIL starve_flits got=%0d want=4", g_cnt); end
      end
      if (t == 8 || t == 10) begin
        n_checks++; if (obs[9:5] !== 5'b0) begin n_fail++; $display("FAIL starve_nogrant t=%0d got=%b want=00000", t, obs[9:5]); end
      end
      if (t == 9) begin
        n_checks++; if (obs[9:5] !== 5'b01000) begin n_fail++; $display("FAIL starve_refill got=%b want=01000", obs[9:5]); end
      end
      if (t == 13) begin
        n_checks++; if (obs[3] !== 1'b0) begin n_fail++; $display("FAIL starve_release got=%b want=0", obs[3]); end
      end
    end
  endtask

  task automatic test_credit_simul_sat();
    logic [9:0] obs, exp;
    apply_reset();
    push_pkt(2, 5);
    req_v = 5'b00100;
    for (int t = 0; t < 7; t++) begin
      if (t == 3) cin_pulse = 1'b1;
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL simul_model t=%0d got=%b want=%b", t, obs, exp); end
      if (t == 3 || t == 4) begin
        n_checks++; if (obs[2:0] !== 3'd2) begin n_fail++; $display("FAIL simul_credit t=%0d got=%0d want=2", t, obs[2:0]); end
        n_checks++; if (obs[9:5] !== 5'b00100) begin n_fail++; $display("FAIL simul_grant t=%0d got=%b want=00100", t, obs[9:5]); end
      end
    end
    for (int k = 0; k < 8; k++) begin
      cin_pulse = 1'b1;
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL sat_model k=%0d got=%b want=%b", k, obs, exp); end
      if (k >= 4) begin
        n_checks++; if (obs[2:0] !== 3'd4) begin n_fail++; $display("FAIL sat_credit k=%0d got=%0d want=4", k, obs[2:0]); end
      end
    end
  endtask

  task automatic test_empty_midpacket();
    logic [9:0] obs, exp;
    apply_reset();
    credit_auto = 1'b1;
    push(1, HEADER);
    push(1, PAYLOAD);
    push_pkt(3, 3);
    req_v = 5'b01010;
    for (int t = 0; t < 14; t++) begin
      if (t == 7) begin
        push(1, PAYLOAD);
        push(1, TAIL);
      end
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL gap_model t=%0d got=%b want=%b", t, obs, exp); end
      if (t >= 3 && t <= 6) begin
        n_checks++; if (obs[9:3] !== 7'b0000001) begin n_fail++; $display("FAIL gap_hold t=%0d got=%b want=0000001", t, obs[9:3]); end
      end
      if (t == 7) begin
        n_checks++; if (obs[9:5] !== 5'b00010) begin n_fail++; $display("FAIL gap_resume got=%b want=00010", obs[9:5]); end
      end
      if (t == 10) begin
        n_checks++; if (obs[9:5] !== 5'b01000) begin n_fail++; $display("FAIL gap_next got=%b want=01000", obs[9:5]); end
      end
    end
  endtask

  task automatic test_reset_midpacket();
    logic [9:0] obs, exp;
    bit hit;
    apply_reset();
    push_pkt(0, 2);
    push_pkt(4, 4);
    req_v = 5'b10001;
    hit = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (m_locked && m_owner == 4 && f_rd[4] == 1) begin
        hit = 1'b1;
        break;
      end
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rstmid_model t=%0d got=%b want=%b", t, obs, exp); end
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL rstmid_setup got=no_lock want=L_locked"); end
    drive_inputs();
    #1;
    n_checks++; if (bus.grant !== 5'b10000) begin n_fail++; $display("FAIL rstmid_pre_grant got=%b want=10000", bus.grant); end
    apply_reset();
    n_checks++; if (bus.grant !== 5'b0) begin n_fail++; $display("FAIL rstmid_grant got=%b want=00000", bus.grant); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.credit_cnt !== 3'd4) begin n_fail++; $display("FAIL rstmid_credit got=%0d want=4", bus.credit_cnt); end
    push_pkt(0, 2);
    push_pkt(4, 2);
    req_v = 5'b10001;
    for (int t = 0; t < 2; t++) begin
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rstmid_after t=%0d got=%b want=%b", t, obs, exp); end
      if (t == 1) begin
        n_checks++; if (obs[9:5] !== 5'b00001) begin n_fail++; $display("FAIL rstmid_prio got=%b want=00001", obs[9:5]); end
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] obs, exp;
    int flits;
    apply_reset();
    flits = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (fsize(i) < 6 && $urandom_range(0, 3) == 0) push_pkt(i, $urandom_range(1, 4));
        req_v[i] = ($urandom_range(0, 3) != 0);
      end
      cin_pulse = ($urandom_range(0, 1) == 1);
      tick(obs, exp);
      n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL random_model t=%0d got=%b want=%b", t, obs, exp); end
      if (obs[4]) flits++;
    end
    n_checks++; if (flits == 0) begin n_fail++; $display("FAIL random_traffic got=0 want=>0"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_v       = '0;
    credit_auto = 1'b0;
    cin_pulse   = 1'b0;
    flush();
    model_reset();
    drive_inputs();
    test_reset();
    test_single_packet();
    test_contention();
    test_credit_starve();
    test_credit_simul_sat();
    test_empty_midpacket();
    test_reset_midpacket();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port packet arbiter for the mesh router. It sits between the five input channels (each with its own FIFO and LBDR routing unit) and one output link, sharing that link between the input channels whose LBDR requests it. Once a packet's HEADER flit wins arbitration, the arbiter locks the output to that input until the TAIL flit leaves. It also tracks downstream buffer space with a credit counter.

## Interface
Parameters:
- NUM_REQ, 5, number of requesting input channels; index 0=N, 1=E, 2=W, 3=S, 4=L.
- CREDIT_MAX, 4, downstream buffer depth in flits; also the credit reset value.
- CREDIT_W, 3, credit counter width; must hold CREDIT_MAX.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  bit i = input i's LBDR port bit for this output.
- empty  in  NUM_REQ  bit i = input i FIFO empty.
- flit_id  in  3*NUM_REQ  head-of-FIFO flit id; [3i+2:3i] belongs to input i.
- credit_in  in  1  one-cycle pulse; downstream freed one slot.
- grant  out  NUM_REQ  one-hot read enable to the winning input FIFO; a flit transfers in every cycle a bit is high.
- valid_out  out  1  flit on output link this cycle; equals |grant.
- credit_cnt  out  CREDIT_W  current free downstream slots.
- busy  out  1  high while in LOCKED.

## Operation
- States: IDLE, LOCKED. Registers: state, owner (index), ptr (last-served index), credit_cnt.
- Input i is eligible when req[i] & ~empty[i] & flit_id[i]==HEADER.
- IDLE: if any input is eligible, select the first eligible index in rotated order ptr+1, ptr+2, … (mod NUM_REQ). Then owner<=winner, state<=LOCKED. No grant is issued in IDLE.
- LOCKED: grant[owner]=~empty[owner] & (credit_cnt!=0). This is combinational from registered state.
- When a transfer occurs with flit_id[owner]==TAIL: state<=IDLE, ptr<=owner.
- A HEADER-and-TAIL single flit (flit_id==HEADER|TAIL) also ends the packet.
- Credit counter:
  - transfer only: decrement.
  - credit_in only: increment.
  - both in the same cycle: unchanged.
  - credit_in at CREDIT_MAX: saturate at CREDIT_MAX.
  - Decrement at 0 cannot happen, because grant is gated by credit.
- Requests from non-owners are ignored while LOCKED. req is not checked during LOCKED; once locked, the packet completes regardless.
- Reset values: state=IDLE, owner=0, ptr=NUM_REQ-1 (so N has first priority), credit_cnt=CREDIT_MAX, grant=0, valid_out=0, busy=0.
- rst mid-packet: the lock is dropped immediately and credits are restored to CREDIT_MAX. The rest of the router resets in the same cycle.

## Timing
- Arbitration latency: eligible HEADER at cycle t leads to LOCKED at t+1, with the HEADER granted at t+1 if credit is available.
- Throughput: one flit per cycle while the owner FIFO is non-empty and credit_cnt>0.
- After TAIL transfers at cycle t, state is IDLE at t+1, and the next HEADER can be granted at t+2 at the earliest. This gives a one-cycle bubble between packets.
- credit_in at cycle t is usable for a grant at t+1.

## Configuration
- ARB_ROUND_ROBIN_EN defined: the rotating-priority selection described above, with ptr updated on TAIL.
- Undefined: fixed priority N>E>W>S>L (lowest index wins). The ptr register is removed and all other behaviour is identical.

## Structure
- Shared package noc_pkg:
  - flit id constants HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100;
  - port index enum (N, E, W, S, L);
  - arbiter state enum.
- Sub-module rr_picker: combinational and parameterized on NUM_REQ. Inputs are the eligible vector and ptr; outputs are a one-hot winner and a valid flag. Under fixed priority it is instantiated with ptr tied to NUM_REQ-1.

## Test plan
- Single packet: reset, then input E sends HEADER, PAYLOAD, TAIL with req[1]=1.
  - Required: grant=5'b00010 on 3 consecutive cycles starting 1 cycle after the HEADER appears.
  - credit_cnt goes 4→1, busy falls after the TAIL.
- Contention with round robin: N and L hold HEADERs at the same time after reset.
  - Required: N is served first; after N's TAIL, L wins.
  - Re-offer N and L HEADERs together: L is not served again before N.
- Credit starvation: CREDIT_MAX=4, send a 6-flit packet with no credit_in.
  - Required: grant stops after 4 flits with credit_cnt=0.
  - A credit_in pulse produces exactly one further grant on the next cycle.
- Simultaneous credit_in and transfer, plus saturation: credit_cnt holds at 2 through the simultaneous cycle.
  - Then extra credit_in pulses at credit_cnt=4 keep it at 4.
- Owner FIFO goes empty mid-packet: grant drops, the lock is held, and a competing HEADER on S is not granted.
  - The flits resume on the owner when it becomes non-empty.
- Reset mid-packet: assert rst during a PAYLOAD.
  - Required: next cycle grant=0, busy=0, credit_cnt=CREDIT_MAX, and N has first priority.
